// File: rtl/usb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_sched_pkg
//  Purpose  : Shared types and constants for the USB transaction scheduler.
//             Holds the scheduler FSM state encoding, the transaction-type
//             codes driven to the host transaction controller, and the
//             frame-number width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package usb_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    TRANS  = 3'd2,
    SETTLE = 3'd3,
    SOF    = 3'd4
  } sched_state_e;

  // Transaction types understood by the host transaction controller
  localparam logic [1:0] SETUP     = 2'b00;
  localparam logic [1:0] IN        = 2'b01;
  localparam logic [1:0] OUT_DATA0 = 2'b10;
  localparam logic [1:0] OUT_DATA1 = 2'b11;

  // USB frame number width
  localparam int FRAME_NUM_W = 11;

endpackage
`default_nettype wire

// File: rtl/usb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rr_arbiter
//  Purpose  : Combinational round-robin pick. Returns the first set request
//             found when searching upward from ptr_i+1 with modulo-N wrap,
//             so the slot at ptr_i itself has the lowest priority.
//  Ports    : req_i  [N-1:0]        request vector
//             ptr_i  [IDX_W-1:0]    index of the most recently granted slot
//             idx_o  [IDX_W-1:0]    picked index (0 when no request is set)
//             any_o                 at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
module usb_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int cand;

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    cand  = 0;
    // Walk from the farthest candidate back to the nearest one so the last
    // assignment made is the nearest set request after ptr_i.
    for (int i = N; i >= 1; i--) begin
      cand = (int'(ptr_i) + i) % N;
      if (req_i[IDX_W'(cand)]) begin
        idx_o = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_trans_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : usb_trans_scheduler
//  Purpose  : Time-shares one host transaction controller between NUM_REQ
//             endpoint requesters, owns the 1 ms frame timer, requests SOF at
//             every frame boundary and blocks new transactions inside the
//             guard window at the end of each frame.
//  Ports    : clk, rst (async, active-low)
//             reqValid/reqType/reqIso  per-slot transaction requests
//             reqDone/reqStatus        per-slot completion pulse + RX status
//             sofEn/sofReq/sofDone     frame timer enable and SOF handshake
//             frameNum                 current 11-bit frame number
//             transReq/transType/isoEn request to the transaction controller
//             transDone/RXStatus       completion from the controller
//             busy                     scheduler not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module usb_trans_scheduler
  import usb_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_TICKS  = 48000,
  parameter int GUARD_TICKS  = 1500,
  parameter int SETTLE_TICKS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [2*NUM_REQ-1:0]   reqType,
  input  logic [NUM_REQ-1:0]     reqIso,
  output logic [NUM_REQ-1:0]     reqDone,
  output logic [7:0]             reqStatus,
  input  logic                   sofEn,
  output logic                   sofReq,
  input  logic                   sofDone,
  output logic [FRAME_NUM_W-1:0] frameNum,
  output logic                   transReq,
  output logic [1:0]             transType,
  output logic                   isoEn,
  input  logic                   transDone,
  input  logic [7:0]             RXStatus,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_TICKS);
  localparam int SET_W = $clog2(SETTLE_TICKS + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] OPEN_LIMIT  = CNT_W'(FRAME_TICKS - GUARD_TICKS);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_TICKS - 1);
  localparam logic [IDX_W-1:0] RR_RESET    = IDX_W'(NUM_REQ - 1);

  sched_state_e           state_q;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   sof_pending_q, sof_pending_d;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       gnt_idx_q;
  logic [SET_W-1:0]       settle_cnt_q;
  logic [FRAME_NUM_W-1:0] frame_num_q;
  logic                   trans_req_q;
  logic [1:0]             trans_type_q;
  logic                   iso_en_q;
  logic                   sof_req_q;
  logic [NUM_REQ-1:0]     req_done_q;
  logic [7:0]             req_status_q;

  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   open_win;
  logic                   sof_ack;

  usb_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (reqValid),
    .ptr_i (rr_ptr_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // With the frame timer off there is no frame end to protect.
  assign open_win = ~sofEn | (frame_cnt_q < OPEN_LIMIT);

  assign sof_ack  = (state_q == SOF) & sofEn & sofDone;

  // Frame timer. A wrap always (re)sets the pending flag and takes precedence
  // over an acknowledge landing in the same cycle, since it opens a new frame;
  // a wrap while already pending simply leaves the single request in place.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    sof_pending_d = sof_pending_q;
    if (!sofEn) begin
      frame_cnt_d   = '0;
      sof_pending_d = 1'b0;
    end else if (frame_cnt_q == FRAME_LAST) begin
      frame_cnt_d   = '0;
      sof_pending_d = 1'b1;
    end else begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (sof_ack) begin
        sof_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q   <= '0;
      sof_pending_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      sof_pending_q <= sof_pending_d;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= RR_RESET;
      gnt_idx_q    <= '0;
      settle_cnt_q <= '0;
      frame_num_q  <= '0;
      trans_req_q  <= 1'b0;
      trans_type_q <= 2'b00;
      iso_en_q     <= 1'b0;
      sof_req_q    <= 1'b0;
      req_done_q   <= '0;
      req_status_q <= 8'h00;
    end else begin
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (sof_pending_q) begin
            sof_req_q <= 1'b1;
            state_q   <= SOF;
          end else if (open_win && arb_any) begin
            state_q <= ARB;
          end
        end

        ARB: begin
          if (arb_any) begin
            gnt_idx_q    <= arb_idx;
            rr_ptr_q     <= arb_idx;
            trans_type_q <= reqType[{arb_idx, 1'b0} +: 2];
            iso_en_q     <= reqIso[arb_idx];
            trans_req_q  <= 1'b1;
            state_q      <= TRANS;
          end else begin
            state_q <= IDLE;
          end
        end

        TRANS: begin
          // reqValid is not consulted here: once granted, the transaction
          // runs to completion.
          if (transDone) begin
            trans_req_q           <= 1'b0;
            req_done_q[gnt_idx_q] <= 1'b1;
            req_status_q          <= RXStatus;
            settle_cnt_q          <= '0;
            state_q               <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= IDLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end

        SOF: begin
          if (!sofEn) begin
            sof_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (sofDone) begin
            sof_req_q   <= 1'b0;
            frame_num_q <= frame_num_q + 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign reqDone   = req_done_q;
  assign reqStatus = req_status_q;
  assign sofReq    = sof_req_q;
  assign frameNum  = frame_num_q;
  assign transReq  = trans_req_q;
  assign transType = trans_type_q;
  assign isoEn     = iso_en_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_trans_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_trans_scheduler
//  Purpose  : Self-checking bench for usb_trans_scheduler. Stimulus pushes
//             expected grant / completion / SOF events into a queue; a
//             monitor pops and compares whenever the DUT presents one.
//             A second, short-frame instance exercises frame-number wrap.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_trans_scheduler;
  import usb_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int FT   = 200;
  localparam int GT   = 40;
  localparam int STK  = 16;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_SOF   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] reqValid = '0;
  logic [2*NREQ-1:0] reqType = '0;
  logic [NREQ-1:0] reqIso = '0;
  logic [NREQ-1:0] reqDone;
  logic [7:0]      reqStatus;
  logic            sofEn = 1'b0;
  logic            sofReq;
  logic            sofDone = 1'b0;
  logic [10:0]     frameNum;
  logic            transReq;
  logic [1:0]      transType;
  logic            isoEn;
  logic            transDone = 1'b0;
  logic [7:0]      RXStatus = 8'h00;
  logic            busy;

  // short-frame instance
  logic            sofEn_f = 1'b0;
  logic            sofDone_f = 1'b0;
  logic            sofReq_f;
  logic [10:0]     frameNum_f;
  logic [NREQ-1:0] reqDone_f;
  logic [7:0]      reqStatus_f;
  logic            transReq_f;
  logic [1:0]      transType_f;
  logic            isoEn_f;
  logic            busy_f;
  logic [NREQ-1:0] zeroReq = '0;
  logic [2*NREQ-1:0] zeroType = '0;
  logic            zeroBit = 1'b0;
  logic [7:0]      zeroByte = 8'h00;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  usb_trans_scheduler #(
    .NUM_REQ(NREQ), .FRAME_TICKS(FT), .GUARD_TICKS(GT), .SETTLE_TICKS(STK)
  ) u_dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqType(reqType),
    .reqIso(reqIso), .reqDone(reqDone), .reqStatus(reqStatus),
    .sofEn(sofEn), .sofReq(sofReq), .sofDone(sofDone), .frameNum(frameNum),
    .transReq(transReq), .transType(transType), .isoEn(isoEn),
    .transDone(transDone), .RXStatus(RXStatus), .busy(busy)
  );

  usb_trans_scheduler #(
    .NUM_REQ(NREQ), .FRAME_TICKS(8), .GUARD_TICKS(2), .SETTLE_TICKS(2)
  ) u_dut_fast (
    .clk(clk), .rst(rst), .reqValid(zeroReq), .reqType(zeroType),
    .reqIso(zeroReq), .reqDone(reqDone_f), .reqStatus(reqStatus_f),
    .sofEn(sofEn_f), .sofReq(sofReq_f), .sofDone(sofDone_f),
    .frameNum(frameNum_f), .transReq(transReq_f), .transType(transType_f),
    .isoEn(isoEn_f), .transDone(zeroBit), .RXStatus(zeroByte), .busy(busy_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void exp_push(input int kind, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_grant(input logic [1:0] t, input logic iso);
    exp_push(EV_GRANT, {29'd0, iso, t});
  endfunction

  function automatic void exp_done(input logic [3:0] oh, input logic [7:0] st);
    exp_push(EV_DONE, {20'd0, oh, st});
  endfunction

  function automatic void exp_sof(input logic [10:0] fn);
    exp_push(EV_SOF, {21'd0, fn});
  endfunction

  // Monitor: compare every presented event with the head of the queue.
  logic prev_tr  = 1'b0;
  logic prev_sof = 1'b0;

  task automatic observe(input int kind, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected kind=%0d actual=%0h required=none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== d) begin
        failures++;
        $display("FAIL sb_event actual=kind%0d:%0h required=kind%0d:%0h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (transReq && !prev_tr) observe(EV_GRANT, {29'd0, isoEn, transType});
    if (reqDone != '0)        observe(EV_DONE, {20'd0, reqDone, reqStatus});
    if (sofReq && !prev_sof)  observe(EV_SOF, {21'd0, frameNum});
    prev_tr  = transReq;
    prev_sof = sofReq;
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tr(output int n);
    n = 0;
    while (transReq !== 1'b1) begin
      if (n >= 400) begin
        checks++;
        failures++;
        $display("FAIL wait_transReq actual=timeout required=transReq");
        return;
      end
      wait_edges(1);
      n++;
    end
  endtask

  task automatic serve_done(input logic [3:0] oh, input logic [7:0] st, input int dly);
    wait_edges(dly);
    exp_done(oh, st);
    RXStatus  = st;
    transDone = 1'b1;
    wait_edges(1);
    transDone = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wait_edges(2);
    rst = 1'b1;
  endtask

  task automatic sof_ack_pulse();
    sofDone = 1'b1;
    wait_edges(1);
    sofDone = 1'b0;
  endtask

  initial begin
    int n;
    int s;
    logic early;
    logic [3:0] isov;
    logic [3:0] oh;

    // ---------------- reset state ----------------
    #1 rst = 1'b0;
    #1;
    chk("rst_transReq", 32'(transReq), 32'd0);
    chk("rst_sofReq", 32'(sofReq), 32'd0);
    chk("rst_reqDone", 32'(reqDone), 32'd0);
    chk("rst_reqStatus", 32'(reqStatus), 32'd0);
    chk("rst_frameNum", 32'(frameNum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    wait_edges(2);
    rst = 1'b1;

    // ---------------- single request, latency and settle gap ----------------
    reqType = 8'b00_01_00_00;
    reqIso  = 4'b0000;
    exp_grant(2'b01, 1'b0);
    reqValid = 4'b0100;
    wait_edges(1);
    chk("lat_arb_transReq", 32'(transReq), 32'd0);
    chk("lat_arb_busy", 32'(busy), 32'd1);
    wait_edges(1);
    chk("lat_trans_transReq", 32'(transReq), 32'd1);
    chk("lat_trans_type", 32'(transType), 32'd1);
    serve_done(4'b0100, 8'h00, 3);
    chk("done_reqDone", 32'(reqDone), 32'h4);
    chk("done_transReq_low", 32'(transReq), 32'd0);
    exp_grant(2'b01, 1'b0);
    wait_tr(n);
    chk("settle_gap", 32'(n), 32'd18);
    serve_done(4'b0100, 8'h5A, 2);
    reqValid = 4'b0000;
    wait_edges(20);

    // ---------------- round robin ----------------
    do_reset();
    reqType = 8'b11_10_01_00;
    isov    = 4'b1010;
    reqIso  = isov;
    for (int k = 0; k < 5; k++) begin
      exp_grant(2'(k % 4), isov[k % 4]);
      if (k == 0) reqValid = 4'b1111;
      wait_tr(n);
      oh = 4'b0001 << (k % 4);
      serve_done(oh, 8'h10 + 8'(k), 2);
    end
    reqValid = 4'b0000;
    wait_edges(20);

    // ---------------- guard window ----------------
    do_reset();
    reqType = 8'b00_00_01_00;
    reqIso  = 4'b0000;
    sofEn = 1'b1;
    s = cyc;
    wait_edges(170);
    exp_sof(11'd0);
    exp_grant(2'b01, 1'b0);
    reqValid = 4'b0010;
    n = 0;
    early = 1'b0;
    while (!sofReq && n < 300) begin
      wait_edges(1);
      n++;
      if (transReq) early = 1'b1;
    end
    chk("guard_sof_latency", 32'(n), 32'd31);
    chk("guard_no_early_grant", 32'(early), 32'd0);
    wait_edges(2);
    sof_ack_pulse();
    chk("guard_frameNum", 32'(frameNum), 32'd1);
    chk("guard_sofReq_low", 32'(sofReq), 32'd0);
    wait_tr(n);
    chk("guard_grant_after_sof", 32'(n), 32'd2);
    serve_done(4'b0010, 8'hA5, 1);
    reqValid = 4'b0000;

    // ---------------- frame wrap during a transaction ----------------
    reqType = 8'b00_10_00_00;
    reqIso  = 4'b0100;
    while ((cyc - s) % FT != 148) wait_edges(1);
    exp_grant(2'b10, 1'b1);
    reqValid = 4'b0100;
    wait_tr(n);
    chk("wrap_grant_cnt", 32'((cyc - s) % FT), 32'd150);
    early = 1'b0;
    while ((cyc - s) % FT != 9) begin
      wait_edges(1);
      if (sofReq) early = 1'b1;
    end
    chk("wrap_no_sof_in_trans", 32'(early), 32'd0);
    exp_done(4'b0100, 8'hC3);
    RXStatus  = 8'hC3;
    transDone = 1'b1;
    wait_edges(1);
    transDone = 1'b0;
    exp_sof(11'd1);
    exp_grant(2'b10, 1'b1);
    n = 0;
    early = 1'b0;
    while (!sofReq && n < 100) begin
      wait_edges(1);
      n++;
      if (transReq) early = 1'b1;
    end
    chk("wrap_sof_after_settle", 32'(n), 32'd17);
    chk("wrap_no_grant_before_sof", 32'(early), 32'd0);
    wait_edges(2);
    sof_ack_pulse();
    chk("wrap_frameNum", 32'(frameNum), 32'd2);
    wait_tr(n);
    serve_done(4'b0100, 8'h3C, 1);
    reqValid = 4'b0000;
    sofEn = 1'b0;
    wait_edges(30);
    chk("wrap_single_sof", 32'(sofReq), 32'd0);

    // ---------------- async reset mid-transaction ----------------
    reqType = 8'b11_10_01_00;
    reqIso  = 4'b0000;
    exp_grant(2'b11, 1'b0);
    reqValid = 4'b1000;
    wait_tr(n);
    wait_edges(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_transReq", 32'(transReq), 32'd0);
    chk("arst_sofReq", 32'(sofReq), 32'd0);
    chk("arst_reqDone", 32'(reqDone), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    reqValid = 4'b1111;
    wait_edges(2);
    rst = 1'b1;
    exp_grant(2'b00, 1'b0);
    wait_tr(n);
    serve_done(4'b0001, 8'h77, 1);
    reqValid = 4'b0000;

    // stray handshakes outside TRANS / SOF
    wait_edges(3);
    transDone = 1'b1;
    sofDone   = 1'b1;
    wait_edges(1);
    transDone = 1'b0;
    sofDone   = 1'b0;
    wait_edges(30);
    chk("stray_frameNum", 32'(frameNum), 32'd0);
    chk("stray_idle", 32'(busy), 32'd0);

    // ---------------- frame number wrap (short-frame instance) ----------------
    sofEn_f = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      n = 0;
      while (!sofReq_f && n < 40) begin
        wait_edges(1);
        n++;
      end
      if (!sofReq_f) begin
        chk("fast_sof_timeout", 32'(sofReq_f), 32'd1);
        break;
      end
      sofDone_f = 1'b1;
      wait_edges(1);
      sofDone_f = 1'b0;
      if (k == 2046) chk("fnum_2047", 32'(frameNum_f), 32'd2047);
    end
    chk("fnum_wrap_0", 32'(frameNum_f), 32'd0);
    sofEn_f = 1'b0;

    wait_edges(5);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
